// File: rtl/pattern_sync_pkg.sv
// Shared state encoding and width helper for the pattern_sync_gen timing source.
package pattern_sync_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    VBLANK
  } psync_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/psync_wrap_cnt.sv
// Wrapping up-counter: counts 0..TERMINAL while enabled, clear forces 0.
module psync_wrap_cnt #(
  parameter int W = 4,
  parameter logic [W-1:0] TERMINAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  // o_wrap flags the terminal count; the count rolls to 0 on the next enabled edge.
  assign o_wrap = (r_cnt == TERMINAL);
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/pattern_sync_gen.sv
// Frame/line timing source feeding the pattern generator.
// Optional frame counter output enabled by defining PSYNC_FRAME_CNT_EN.
module pattern_sync_gen
  import pattern_sync_pkg::*;
#(
  parameter int H_ACTIVE = 64,
  parameter int H_BLANK  = 8,
  parameter int V_ACTIVE = 48,
  parameter int V_BLANK  = 2,
  localparam int H_TOTAL = H_ACTIVE + H_BLANK,
  localparam int V_TOTAL = V_ACTIVE + V_BLANK,
  localparam int XW      = clog2_min1(H_TOTAL),
  localparam int YW      = clog2_min1(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          continuous,
  output logic          f_sync,
  output logic          sync,
  output logic          active,
  output logic [XW-1:0] x_pos,
  output logic [YW-1:0] y_pos,
  output logic          frame_done,
  output logic          busy
`ifdef PSYNC_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam logic [XW-1:0] H_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_PRE_LAST = XW'(H_TOTAL - 2);
  localparam logic [YW-1:0] V_ACT_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);

  psync_state_t r_state;
  psync_state_t w_state_next;
  logic         w_in_frame;
  logic         w_eof;
  logic         w_new_frame;
  logic         w_last_next;
  logic         w_h_wrap;
  logic         w_v_wrap;

  assign w_in_frame = (r_state != IDLE);

  psync_wrap_cnt #(
    .W        (XW),
    .TERMINAL (H_LAST)
  ) u_h_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_in_frame),
    .i_clr  (!w_in_frame),
    .o_cnt  (x_pos),
    .o_wrap (w_h_wrap)
  );

  psync_wrap_cnt #(
    .W        (YW),
    .TERMINAL (V_LAST)
  ) u_v_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_in_frame && w_h_wrap),
    .i_clr  (!w_in_frame),
    .o_cnt  (y_pos),
    .o_wrap (w_v_wrap)
  );

  always_comb begin
    w_state_next = r_state;
    w_eof        = 1'b0;
    case (r_state)
      IDLE:    if (start) w_state_next = ACTIVE;
      ACTIVE:  if (x_pos == H_ACT_LAST) w_state_next = HBLANK;
      HBLANK: begin
        if (w_h_wrap) begin
          if (y_pos < V_ACT_LAST)  w_state_next = ACTIVE;
          else if (V_BLANK > 0)    w_state_next = VBLANK;
          else                     w_eof        = 1'b1;
        end
      end
      VBLANK:  if (w_h_wrap && w_v_wrap) w_eof = 1'b1;
      default: w_state_next = IDLE;
    endcase
    if (w_eof) w_state_next = continuous ? ACTIVE : IDLE;
  end

  assign w_new_frame = ((r_state == IDLE) && start) || (w_eof && continuous);
  // frame_done is registered, so flag the cycle before the last (h,v) position.
  assign w_last_next = w_in_frame && (x_pos == H_PRE_LAST) && (y_pos == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      f_sync     <= 1'b0;
      sync       <= 1'b0;
      active     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      f_sync     <= w_new_frame;
      sync       <= (w_state_next == ACTIVE) && (r_state != ACTIVE);
      active     <= (w_state_next == ACTIVE);
      frame_done <= w_last_next;
      busy       <= (w_state_next != IDLE);
    end
  end

`ifdef PSYNC_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (frame_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_pattern_sync_gen.sv
// Self-checking bench for pattern_sync_gen: directed test-plan scenarios then random stimulus.
module tb_pattern_sync_gen;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int HT = HA + HB;

  logic clk = 1'b0;
  logic rst, start, continuous;

  logic       fs0, sy0, ac0, fd0, bz0;
  logic [2:0] x0;
  logic [1:0] y0;
  logic       fs1, sy1, ac1, fd1, bz1;
  logic [2:0] x1;
  logic [1:0] y1;
`ifdef PSYNC_FRAME_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  pattern_sync_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(1)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .f_sync(fs0), .sync(sy0), .active(ac0), .x_pos(x0), .y_pos(y0),
    .frame_done(fd0), .busy(bz0)
`ifdef PSYNC_FRAME_CNT_EN
    , .frame_cnt(cnt0)
`endif
  );

  pattern_sync_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(0)) dut_vb0 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .f_sync(fs1), .sync(sy1), .active(ac1), .x_pos(x1), .y_pos(y1),
    .frame_done(fd1), .busy(bz1)
`ifdef PSYNC_FRAME_CNT_EN
    , .frame_cnt(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  int last_fd0 = -1;
  int fs_cnt0 = 0;
  int m_in[2];
  int m_t[2];
  logic [15:0] m_cnt[2];
  logic [15:0] saved_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Model: a frame is just a position t in 0..HT*vt-1; everything else follows from t.
  task automatic model_edge(input int k, input int fl);
    if (rst) begin
      m_in[k] = 0; m_t[k] = 0; m_cnt[k] = 16'd0;
    end else if (m_in[k] == 0) begin
      if (start) begin m_in[k] = 1; m_t[k] = 0; end
    end else if (m_t[k] == fl - 1) begin
      m_cnt[k] = m_cnt[k] + 16'd1;
      if (continuous) m_t[k] = 0;
      else m_in[k] = 0;
    end else begin
      m_t[k] = m_t[k] + 1;
    end
  endtask

  task automatic check_dut(input int k, input int fl, input logic fs, input logic sy,
                           input logic ac, input logic fd, input logic bz,
                           input logic [2:0] x, input logic [1:0] y);
    int t, xe, ye;
    bit in;
    in = (m_in[k] != 0);
    t  = m_t[k];
    xe = in ? t % HT : 0;
    ye = in ? t / HT : 0;
    check($sformatf("d%0d_f_sync", k), 32'(fs), 32'(in && t == 0));
    check($sformatf("d%0d_sync", k), 32'(sy), 32'(in && xe == 0 && ye < VA));
    check($sformatf("d%0d_active", k), 32'(ac), 32'(in && xe < HA && ye < VA));
    check($sformatf("d%0d_frame_done", k), 32'(fd), 32'(in && t == fl - 1));
    check($sformatf("d%0d_busy", k), 32'(bz), 32'(in));
    check($sformatf("d%0d_x_pos", k), 32'(x), 32'(xe));
    check($sformatf("d%0d_y_pos", k), 32'(y), 32'(ye));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(0, HT * 4);
    model_edge(1, HT * 3);
    #1;
    check_dut(0, HT * 4, fs0, sy0, ac0, fd0, bz0, x0, y0);
    check_dut(1, HT * 3, fs1, sy1, ac1, fd1, bz1, x1, y1);
`ifdef PSYNC_FRAME_CNT_EN
    check("d0_frame_cnt", 32'(cnt0), 32'(m_cnt[0]));
    check("d1_frame_cnt", 32'(cnt1), 32'(m_cnt[1]));
`endif
    if (fd0 === 1'b1) last_fd0 = cyc - base;
    if (fs0 === 1'b1) fs_cnt0++;
  endtask

  initial begin
    m_in = '{0, 0}; m_t = '{0, 0}; m_cnt = '{16'd0, 16'd0};
    rst = 1'b1; start = 1'b0; continuous = 1'b0;
    step(); step();
    check("rst_busy", 32'(bz0), 32'd0);
    check("rst_f_sync", 32'(fs0), 32'd0);
    check("rst_x_pos", 32'(x0), 32'd0);
    rst = 1'b0;
    step();

    // Single frame.
    base = cyc; last_fd0 = -1; fs_cnt0 = 0;
    start = 1'b1; step(); start = 1'b0;
    check("s1_f_sync_c1", 32'(fs0), 32'd1);
    check("s1_sync_c1", 32'(sy0), 32'd1);
    repeat (25) step();
    check("s1_frame_done_cycle", 32'(last_fd0), 32'd24);
    check("s1_f_sync_count", 32'(fs_cnt0), 32'd1);
    check("s1_idle_busy", 32'(bz0), 32'd0);

    // Continuous, dropped at cycle 30.
    base = cyc; last_fd0 = -1; fs_cnt0 = 0;
    continuous = 1'b1; start = 1'b1; step(); start = 1'b0;
    repeat (24) step();
    check("s2_f_sync_c25", 32'(fs0), 32'd1);
    check("s2_busy_c25", 32'(bz0), 32'd1);
    repeat (5) step();
    continuous = 1'b0;
    repeat (19) step();
    check("s2_frame_done_cycle", 32'(last_fd0), 32'd48);
    check("s2_f_sync_count", 32'(fs_cnt0), 32'd2);
    check("s2_busy_c49", 32'(bz0), 32'd0);
    repeat (3) step();

    // start re-pulsed at 5 and 24 during frame.
    base = cyc; last_fd0 = -1; fs_cnt0 = 0;
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (18) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (2) step();
    check("s3_frame_done_cycle", 32'(last_fd0), 32'd24);
    check("s3_f_sync_count", 32'(fs_cnt0), 32'd1);
    repeat (20) step();

    // rst at cycle 9.
    base = cyc; last_fd0 = -1; fs_cnt0 = 0;
    start = 1'b1; step(); start = 1'b0;
    repeat (8) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("s4_busy_c10", 32'(bz0), 32'd0);
    check("s4_active_c10", 32'(ac0), 32'd0);
    check("s4_x_pos_c10", 32'(x0), 32'd0);
    repeat (2) step();
    start = 1'b1; step(); start = 1'b0;
    check("s4_f_sync_c13", 32'(fs0), 32'd1);
    check("s4_no_frame_done", 32'(last_fd0), 32'hFFFF_FFFF);
    repeat (30) step();
    check("s4_frame_done_cycle", 32'(last_fd0), 32'd36);

    // V_BLANK=0 instance, continuous.
    base = cyc; saved_cnt = m_cnt[1];
    continuous = 1'b1; start = 1'b1; step(); start = 1'b0;
    repeat (17) step();
    check("s5_frame_done_c18", 32'(fd1), 32'd1);
    step();
    check("s5_f_sync_c19", 32'(fs1), 32'd1);
`ifdef PSYNC_FRAME_CNT_EN
    check("s5_frame_cnt_c19", 32'(cnt1), 32'(saved_cnt + 16'd1));
`endif
    continuous = 1'b0;
    repeat (30) step();

    // Randomized stimulus.
    repeat (3000) begin
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) continuous = ~continuous;
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; start = 1'b0; continuous = 1'b0;
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
